jstk_spi_master: RTL

- SPI master that polls the PmodJSTK joystick and sits directly upstream of the game logic in Space_Invaders_Top.
- Drives the SS/MOSI/SCLK pins and receives MISO.
- Runs one 5-byte SPI mode-0 transaction per start request and presents registered X/Y position and button state with a one-cycle valid strobe.
- The same transaction sends the joystick LED command byte.

---
 rtl/jstk_pkg.sv | 29 ++
 rtl/jstk_spi_master_if.sv | 25 ++
 rtl/jstk_spi_master_shifter.sv | 62 ++++++
 rtl/jstk_spi_master.sv | 125 ++++++++++++
 4 files changed

// File: rtl/jstk_pkg.sv
// Shared constants and types for the PmodJSTK SPI master: FSM encoding,
// receive byte map and counter sizing helper.
package jstk_pkg;

  localparam int         JSTK_NUM_BYTES  = 5;
  localparam logic [5:0] JSTK_CMD_PREFIX = 6'b100000;

  typedef enum logic [2:0] {
    IDLE,
    SS_SETUP,
    SHIFT,
    GAP,
    DONE
  } jstk_state_t;

  typedef logic [2:0] byte_idx_t;

  localparam byte_idx_t X_LO = 3'd0;
  localparam byte_idx_t X_HI = 3'd1;
  localparam byte_idx_t Y_LO = 3'd2;
  localparam byte_idx_t Y_HI = 3'd3;
  localparam byte_idx_t BTN  = byte_idx_t'(JSTK_NUM_BYTES - 1);

  // A count of 1 still needs a 1-bit register.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/jstk_spi_master_if.sv
// Joystick master bus: request/result signals plus the four SPI pins.
// master = the SPI master block, slave = whatever drives start and the joystick side.
interface jstk_spi_master_if;
  logic       start;
  logic [1:0] led_cmd;
  logic       MISO;
  logic       SS;
  logic       SCLK;
  logic       MOSI;
  logic       busy;
  logic [9:0] x_pos;
  logic [9:0] y_pos;
  logic [2:0] buttons;
  logic       data_valid;

  modport master (
    input  start, led_cmd, MISO,
    output SS, SCLK, MOSI, busy, x_pos, y_pos, buttons, data_valid
  );

  modport slave (
    output start, led_cmd, MISO,
    input  SS, SCLK, MOSI, busy, x_pos, y_pos, buttons, data_valid
  );
endinterface

// File: rtl/jstk_spi_master_shifter.sv
// One-byte SPI mode-0 engine, MSB first: 16*SCLK_HALF clocks per byte while go is held.
// No backpressure; byte_done is a combinational pulse on the final SCLK fall.
module spi_byte_shifter
  import jstk_pkg::*;
#(
  parameter int SCLK_HALF = 50
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] tx_byte,
  input  logic       go,
  input  logic       miso,
  output logic       sclk,
  output logic       mosi,
  output logic [7:0] rx_byte,
  output logic       byte_done
);

  localparam int HW = cnt_w(SCLK_HALF);

  logic [HW-1:0] hcnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    tx_sr;
  logic [7:0]    rx_sr;
  logic          half_end;

  assign half_end  = go && (hcnt == HW'(SCLK_HALF - 1));
  assign byte_done = half_end && sclk && (bit_cnt == 3'd7);
  assign mosi      = tx_sr[7];
  assign rx_byte   = rx_sr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hcnt    <= '0;
      bit_cnt <= '0;
      sclk    <= 1'b0;
      tx_sr   <= '0;
      rx_sr   <= '0;
    end else if (load) begin
      hcnt    <= '0;
      bit_cnt <= '0;
      sclk    <= 1'b0;
      tx_sr   <= tx_byte;
    end else if (go) begin
      if (half_end) begin
        hcnt <= '0;
        sclk <= ~sclk;
        // Sample on the rising edge, advance MOSI on the falling edge.
        if (!sclk) begin
          rx_sr <= {rx_sr[6:0], miso};
        end else begin
          tx_sr   <= {tx_sr[6:0], 1'b0};
          bit_cnt <= bit_cnt + 3'd1;
        end
      end else begin
        hcnt <= hcnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/jstk_spi_master.sv
// PmodJSTK poller: one 5-byte SPI transaction per accepted start, then x/y/buttons with a data_valid pulse.
// Latency 1+SS_SETUP_CYC+80*SCLK_HALF+4*BYTE_GAP_CYC+1 clocks; start is ignored while busy.
module jstk_spi_master
  import jstk_pkg::*;
#(
  parameter int SCLK_HALF    = 50,
  parameter int SS_SETUP_CYC = 1500,
  parameter int BYTE_GAP_CYC = 1000
) (
  input logic                ClkPort,
  input logic                Reset_bar,
  jstk_spi_master_if.master  bus
);

  localparam int SW = cnt_w(SS_SETUP_CYC);
  localparam int GW = cnt_w(BYTE_GAP_CYC);

  jstk_state_t   state, next_state;
  logic [SW-1:0] setup_cnt;
  logic [GW-1:0] gap_cnt;
  byte_idx_t     byte_idx;
  logic [7:0]    cmd;
  logic [7:0]    x_lo, y_lo;
  logic [1:0]    x_hi, y_hi;
  logic [9:0]    x_pos_q, y_pos_q;
  logic [2:0]    buttons_q;

  logic          sh_load, sh_go, sh_sclk, sh_mosi, byte_done;
  logic [7:0]    tx_byte, rx_byte;

  assign tx_byte = (byte_idx == X_LO) ? cmd : 8'h00;

  spi_byte_shifter #(.SCLK_HALF(SCLK_HALF)) u_shifter (
    .clk       (ClkPort),
    .rst_n     (Reset_bar),
    .load      (sh_load),
    .tx_byte   (tx_byte),
    .go        (sh_go),
    .miso      (bus.MISO),
    .sclk      (sh_sclk),
    .mosi      (sh_mosi),
    .rx_byte   (rx_byte),
    .byte_done (byte_done)
  );

  always_ff @(posedge ClkPort) begin
    if (!Reset_bar) state <= IDLE;
    else            state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:     if (bus.start) next_state = SS_SETUP;
      SS_SETUP: if (setup_cnt == SW'(SS_SETUP_CYC - 1)) next_state = SHIFT;
      SHIFT:    if (byte_done) next_state = (byte_idx == BTN) ? DONE : GAP;
      GAP:      if (gap_cnt == GW'(BYTE_GAP_CYC - 1)) next_state = SHIFT;
      DONE:     next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  always_comb begin
    sh_go   = (state == SHIFT);
    sh_load = (next_state == SHIFT) && (state != SHIFT);
    bus.SS         = !((state == SS_SETUP) || (state == SHIFT) || (state == GAP));
    bus.busy       = (state != IDLE);
    bus.data_valid = (state == DONE);
    bus.SCLK       = sh_sclk;
    case (state)
      SS_SETUP, GAP: bus.MOSI = tx_byte[7];
      SHIFT:         bus.MOSI = sh_mosi;
      default:       bus.MOSI = 1'b0;
    endcase
  end

  always_ff @(posedge ClkPort) begin
    if (!Reset_bar) begin
      setup_cnt <= '0;
      gap_cnt   <= '0;
      byte_idx  <= X_LO;
      cmd       <= '0;
      x_lo      <= '0;
      x_hi      <= '0;
      y_lo      <= '0;
      y_hi      <= '0;
      x_pos_q   <= '0;
      y_pos_q   <= '0;
      buttons_q <= '0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          cmd       <= {JSTK_CMD_PREFIX, bus.led_cmd};
          setup_cnt <= '0;
          byte_idx  <= X_LO;
        end
        SS_SETUP: setup_cnt <= setup_cnt + 1'b1;
        SHIFT: if (byte_done) begin
          gap_cnt  <= '0;
          byte_idx <= byte_idx + 3'd1;
          // Outputs only move once the final byte lands, so they never mix two polls.
          case (byte_idx)
            X_LO: x_lo <= rx_byte;
            X_HI: x_hi <= rx_byte[1:0];
            Y_LO: y_lo <= rx_byte;
            Y_HI: y_hi <= rx_byte[1:0];
            BTN: begin
              x_pos_q   <= {x_hi, x_lo};
              y_pos_q   <= {y_hi, y_lo};
              buttons_q <= rx_byte[2:0];
            end
            default: ;
          endcase
        end
        GAP: gap_cnt <= gap_cnt + 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.x_pos   = x_pos_q;
  assign bus.y_pos   = y_pos_q;
  assign bus.buttons = buttons_q;

endmodule
